// File: rtl/jtag_master_pkg.sv
// rtl/jtag_master_pkg.sv - shared encodings, sequence lengths and TMS helper for the JTAG master
package jtag_master_pkg;

  localparam logic [1:0] JTAG_OP_RESET = 2'd0;
  localparam logic [1:0] JTAG_OP_IR    = 2'd1;
  localparam logic [1:0] JTAG_OP_DR    = 2'd2;
  localparam logic [1:0] JTAG_OP_IDLE  = 2'd3;

  localparam logic [7:0] JTAG_IR_PRE    = 8'd4;
  localparam logic [7:0] JTAG_DR_PRE    = 8'd3;
  localparam logic [7:0] JTAG_SUFFIX    = 8'd2;
  localparam logic [7:0] JTAG_RESET_LEN = 8'd6;

  localparam int JTAG_MAX_BITS_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RESP
  } jtag_state_t;

  // TMS value for TCK cycle idx of a command; every sequence starts and ends in Run-Test/Idle.
  function automatic logic jtag_tms_at(input logic [1:0] op, input logic [6:0] len,
                                       input logic [7:0] idx);
    logic [7:0] l;
    logic       t;
    l = {1'b0, len};
    t = 1'b0;
    case (op)
      JTAG_OP_RESET: t = (idx < JTAG_RESET_LEN - 8'd1);
      JTAG_OP_IR: begin
        if (idx < 8'd2)                    t = 1'b1;
        else if (idx < JTAG_IR_PRE)        t = 1'b0;
        else if (idx < JTAG_IR_PRE + l)    t = (idx == JTAG_IR_PRE + l - 8'd1);
        else                               t = (idx == JTAG_IR_PRE + l);
      end
      JTAG_OP_DR: begin
        if (idx == 8'd0)                   t = 1'b1;
        else if (idx < JTAG_DR_PRE)        t = 1'b0;
        else if (idx < JTAG_DR_PRE + l)    t = (idx == JTAG_DR_PRE + l - 8'd1);
        else                               t = (idx == JTAG_DR_PRE + l);
      end
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/jtag_master_seq_tck_gen.sv
// rtl/jtag_master_seq_tck_gen.sv - TCK phase generator with fall/rise strobes
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tck,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tck;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cnt == CW'(CLK_DIV - 1));

  // Phase counter: held at the start of a low phase whenever disabled so each enable restarts cleanly.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tck  = r_tck;
  assign o_rise = w_wrap && !r_tck;
  assign o_fall = w_wrap && r_tck;

endmodule

// File: rtl/jtag_master_seq.sv
// rtl/jtag_master_seq.sv - command/response JTAG master driving the debug TAP pins
module jtag_master_seq
  import jtag_master_pkg::*;
#(
  parameter int MAX_BITS = JTAG_MAX_BITS_DEF,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [6:0]          cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                rsp_err,
  output logic                tap_sync,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  jtag_state_t         r_state, w_state_nxt;
  logic [1:0]          r_op;
  logic [6:0]          r_len;
  logic [7:0]          r_k;
  logic [7:0]          r_idx;
  logic [MAX_BITS-1:0] r_tdi_sr;
  logic [MAX_BITS-1:0] r_mask;
  logic [MAX_BITS-1:0] r_rsp_data;
  logic                r_rsp_err;
  logic                r_tms;
  logic                r_tdi;
  logic                r_tap_sync;

  logic                w_accept;
  logic                w_cmd_err;
  logic [7:0]          w_cmd_k;
  logic                w_rise;
  logic                w_fall;
  logic                w_last;
  logic [7:0]          w_idx_nxt;
  logic [7:0]          w_pre;
  logic                w_is_shift_op;
  logic                w_shift_cur;
  logic                w_shift_nxt;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (r_state == ST_RUN),
    .o_tck  (tck),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_last    = (r_idx == r_k - 8'd1);
  assign w_idx_nxt = r_idx + 8'd1;

  // Command decode: TCK cycle count and rejection check, evaluated on the offered command.
  always_comb begin
    w_cmd_k   = 8'd0;
    w_cmd_err = 1'b0;
    case (cmd_op)
      JTAG_OP_RESET: w_cmd_k = JTAG_RESET_LEN;
      JTAG_OP_IR:    w_cmd_k = {1'b0, cmd_len} + JTAG_IR_PRE + JTAG_SUFFIX;
      JTAG_OP_DR:    w_cmd_k = {1'b0, cmd_len} + JTAG_DR_PRE + JTAG_SUFFIX;
      default:       w_cmd_k = {1'b0, cmd_len};
    endcase
    if ((cmd_op == JTAG_OP_IR || cmd_op == JTAG_OP_DR) &&
        (cmd_len == 7'd0 || {1'b0, cmd_len} > 8'(MAX_BITS)))
      w_cmd_err = 1'b1;
    if (cmd_op != JTAG_OP_RESET && !r_tap_sync)
      w_cmd_err = 1'b1;
  end

  // Shift window of the running command, for the current and the upcoming TCK cycle.
  always_comb begin
    w_is_shift_op = (r_op == JTAG_OP_IR) || (r_op == JTAG_OP_DR);
    w_pre         = (r_op == JTAG_OP_IR) ? JTAG_IR_PRE : JTAG_DR_PRE;
    w_shift_cur   = w_is_shift_op && (r_idx >= w_pre) && (r_idx < w_pre + {1'b0, r_len});
    w_shift_nxt   = w_is_shift_op && (w_idx_nxt >= w_pre) &&
                    (w_idx_nxt < w_pre + {1'b0, r_len});
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: rejected or zero-length commands skip RUN and respond at once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = (w_cmd_err || w_cmd_k == 8'd0) ? ST_RESP : ST_RUN;
      ST_RUN:  if (w_fall && w_last) w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch command, drive TMS/TDI at each low phase, capture TDO at each rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= JTAG_OP_RESET;
      r_len      <= 7'd0;
      r_k        <= 8'd0;
      r_idx      <= 8'd0;
      r_tdi_sr   <= '0;
      r_mask     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_tms      <= 1'b1;
      r_tdi      <= 1'b0;
      r_tap_sync <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op       <= cmd_op;
            r_len      <= cmd_len;
            r_k        <= w_cmd_k;
            r_idx      <= 8'd0;
            r_tdi_sr   <= cmd_data;
            r_mask     <= MAX_BITS'(1);
            r_rsp_data <= '0;
            r_rsp_err  <= w_cmd_err;
            r_tdi      <= 1'b0;
            if (!w_cmd_err && w_cmd_k != 8'd0)
              r_tms <= jtag_tms_at(cmd_op, cmd_len, 8'd0);
          end
        end
        ST_RUN: begin
          if (w_rise && w_shift_cur) begin
            if (tdo) r_rsp_data <= r_rsp_data | r_mask;
            r_mask <= r_mask << 1;
          end
          if (w_fall) begin
            if (w_last) begin
              r_tms <= 1'b0;
              r_tdi <= 1'b0;
              if (r_op == JTAG_OP_RESET) r_tap_sync <= 1'b1;
            end else begin
              r_idx <= w_idx_nxt;
              r_tms <= jtag_tms_at(r_op, r_len, w_idx_nxt);
              if (w_shift_nxt) begin
                r_tdi    <= r_tdi_sr[0];
                r_tdi_sr <= r_tdi_sr >> 1;
              end else begin
                r_tdi <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign tap_sync  = r_tap_sync;
  assign tms       = r_tms;
  assign tdi       = r_tdi;

endmodule
